hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised pipeline hazard unit that sits beside the decode stage. It tracks in-flight register writes in a shadow pipeline of configurable depth, stalls fetch/decode on read-after-write hazards, and flushes fetch/decode on taken jumps. Relative to the fixed 3-stage hazard logic it adds:
- optional load-use-only mode for cores with forwarding;
- write-through register file support;
- multi-cycle redirect flush;
- a saturating stall-cycle counter.

## Interface
- NUM_REGS, 32, architectural register count; register 0 is hard-wired zero.
- REG_AW, $clog2(NUM_REGS), register index width.
- PIPE_DEPTH, 3, stages from execute through writeback (minimum 1).
- WB_BYPASS, 0, 1 = register file is write-through, so the last shadow stage never causes a hazard.
- FWD_EN, 0, 1 = forwarding present; only a load in stage 0 causes a hazard.
- FLUSH_CYCLES, 1, extra cycles flush_fd stays high after a jump (0..7).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- issue_valid  in  1  decode holds a valid instruction
- rd_mask  in  2  bit0 = reads rs1, bit1 = reads rs2
- rs1, rs2  in  REG_AW  source indices
- we  in  1  decoded instruction writes rd
- rd  in  REG_AW  destination index
- is_load  in  1  decoded instruction is a load
- jump  in  1  taken jump/branch resolved in execute this cycle
- stall_fd  out  1  hold PC and the F/D register
- bubble_e  out  1  load a bubble into the D/E register
- flush_fd  out  1  kill fetch and decode contents
- state  out  2  FSM state, encoded per package
- stall_cnt  out  CNT_W  saturating count of stall cycles
- stat_clr  in  1  synchronous clear of stall_cnt

## Operation
- **Shadow pipeline:** PIPE_DEPTH entries of {valid, we, rd, is_load}. It shifts every clock and never stalls; stage 0 corresponds to execute.
- **What enters stage 0:** the decoded instruction when issue_valid && !stall_fd && !flush_fd. Otherwise a bubble (valid=0) enters.
- **Matching entry:** valid && we && rd!=0.
- **Hazard, FWD_EN=0:** an enabled source (rd_mask bit set) equals rd of a matching entry in stages 0..LAST, where LAST = PIPE_DEPTH-1-WB_BYPASS. If LAST<0, no hazard is ever raised.
- **Hazard, FWD_EN=1:** only a matching stage-0 entry with is_load=1 counts.
- **Source 0:** a source index of 0 never matches.
- **Outputs:** stall_fd = hazard && issue_valid && !flush_fd. bubble_e = stall_fd || flush_fd.
- **FSM states:** RUN(0), STALL(1), FLUSH(2).
  - RUN: jump → FLUSH (if FLUSH_CYCLES>0), else hazard → STALL, else RUN.
  - STALL: jump → FLUSH, else hazard → STALL, else RUN.
  - FLUSH: a down-counter loaded with FLUSH_CYCLES-1 on entry. Exit to RUN when it reaches 0. A new jump reloads the counter. A hazard is ignored while in FLUSH.
- **flush_fd:** jump || (state==FLUSH).
- **Simultaneous jump and hazard:** the jump wins. flush_fd=1, stall_fd=0, and a bubble is issued.
- **stall_cnt:** increments on each cycle with stall_fd=1, saturating at all-ones. stat_clr takes priority over increment.

## Timing
- Reset values: shadow pipeline all invalid, state=RUN, FLUSH counter=0, stall_cnt=0. As a result stall_fd=0, bubble_e=0, flush_fd=0.
- The hazard path is combinational from decode inputs to stall_fd, bubble_e and flush_fd within the same cycle.
- Producer issued at edge t0 with consumer immediately behind it:
  - FWD_EN=0: stall_fd is high for LAST+1 cycles (3 at defaults), then the consumer issues.
  - FWD_EN=1: a load producer gives exactly 1 stall cycle; a non-load producer gives 0.
- flush_fd is high in the jump cycle plus FLUSH_CYCLES following cycles.
- Reset mid-stall or mid-flush: all state clears asynchronously; outputs are low while reset is held.

## Structure
- hazard_pkg holds:
  - state encodings ST_RUN, ST_STALL, ST_FLUSH;
  - typedef shadow_entry_t {valid, we, rd, is_load};
  - function src_match(entry, idx).
- Sub-module hazard_shadow_pipe: a PIPE_DEPTH shift register of shadow_entry_t with asynchronous clear, exposing all entries as a flat vector.
- The top level contains the hazard compare, the FSM, the flush counter and the stall counter.

## Test plan
- RAW, defaults: issue we=1 rd=5; the next instruction reads rs1=5 → stall_fd=1 for 3 cycles, bubble_e=1, stall_cnt=3, then issue. With WB_BYPASS=1 → 2 cycles.
- Writes to x0: issue we=1 rd=0, then read rs1=0 → no stall. rd_mask=00 with a matching rs1 → no stall.
- FWD_EN=1: load to rd=7 followed by a read of rs2=7 → 1 stall cycle. ALU write to rd=7 followed by the same read → 0 stall cycles.
- Jump with FLUSH_CYCLES=2 in the same cycle as a hazard → flush_fd high 3 cycles, stall_fd=0 throughout, state RUN→FLUSH→FLUSH→RUN.
- Back-to-back jumps: a second jump in the last FLUSH cycle → counter reloads, flush_fd continuous for 3 more cycles.
- CNT_W=4, continuous hazard → stall_cnt saturates at 15. stat_clr → 0 next cycle. Reset asserted mid-STALL → all outputs 0, state=RUN immediately.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: FSM encoding, shadow-pipeline entry, source match helper.
package hazard_pkg;

  // Entry rd field is sized for the widest supported register index; narrower indices are zero-extended.
  localparam int unsigned REG_AW_MAX = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [REG_AW_MAX-1:0] rd;
    logic                  is_load;
  } shadow_entry_t;

  function automatic logic src_match(input shadow_entry_t entry, input logic [REG_AW_MAX-1:0] idx);
    return entry.valid && entry.we && (entry.rd != '0) && (entry.rd == idx);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard handshake: decoded instruction fields in, stall/bubble/flush controls out.
interface hazard_scoreboard_if #(
  parameter int unsigned REG_AW = 5
);
  logic              issue_valid;
  logic [1:0]        rd_mask;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              we;
  logic [REG_AW-1:0] rd;
  logic              is_load;
  logic              jump;
  logic              stall_fd;
  logic              bubble_e;
  logic              flush_fd;

  modport master (
    output issue_valid, rd_mask, rs1, rs2, we, rd, is_load, jump,
    input  stall_fd, bubble_e, flush_fd
  );

  modport slave (
    input  issue_valid, rd_mask, rs1, rs2, we, rd, is_load, jump,
    output stall_fd, bubble_e, flush_fd
  );
endinterface

// File: rtl/hazard_scoreboard_shadow_pipe.sv
// Non-stalling shift register of in-flight writes; stage 0 is execute.
module hazard_shadow_pipe
  import hazard_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 3
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  shadow_entry_t                               entry_in,
  output logic [PIPE_DEPTH*$bits(shadow_entry_t)-1:0] entries
);

  shadow_entry_t [PIPE_DEPTH-1:0] stage;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage <= '0;
    end else begin
      stage[0] <= entry_in;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign entries = stage;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit: RAW stall detection, jump flush sequencing and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned REG_AW       = $clog2(NUM_REGS),
  parameter int unsigned PIPE_DEPTH   = 3,
  parameter int unsigned WB_BYPASS    = 0,
  parameter int unsigned FWD_EN       = 0,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_scoreboard_if.slave   dec,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     stall_cnt,
  input  logic                 stat_clr
);

  localparam int LAST = int'(PIPE_DEPTH) - 1 - int'(WB_BYPASS);
  localparam logic [2:0] FLUSH_RELOAD = (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;

  logic [PIPE_DEPTH*$bits(shadow_entry_t)-1:0] flat;
  shadow_entry_t [PIPE_DEPTH-1:0]              shadow;
  shadow_entry_t                               entry_in;
  logic [REG_AW_MAX-1:0]                       rs1_x;
  logic [REG_AW_MAX-1:0]                       rs2_x;
  logic [PIPE_DEPTH-1:0]                       hit;
  logic                                        hazard;
  logic                                        stall;
  logic                                        flush;
  state_t                                      st;
  logic [2:0]                                  flush_left;

  assign rs1_x  = REG_AW_MAX'(dec.rs1);
  assign rs2_x  = REG_AW_MAX'(dec.rs2);
  assign shadow = flat;

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
      hit[i] = (dec.rd_mask[0] && src_match(shadow[i], rs1_x)) ||
               (dec.rd_mask[1] && src_match(shadow[i], rs2_x));
    end
  end

  // With forwarding only an execute-stage load is unresolved; otherwise any producer up to LAST blocks.
  always_comb begin
    hazard = 1'b0;
    if (FWD_EN != 0) begin
      hazard = hit[0] && shadow[0].is_load;
    end else begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        if (int'(i) <= LAST) hazard = hazard | hit[i];
      end
    end
  end

  assign flush        = dec.jump || (st == ST_FLUSH);
  assign stall        = hazard && dec.issue_valid && !flush;
  assign dec.flush_fd = flush;
  assign dec.stall_fd = stall;
  assign dec.bubble_e = stall || flush;

  always_comb begin
    entry_in         = '0;
    entry_in.valid   = dec.issue_valid && !stall && !flush;
    entry_in.we      = dec.we;
    entry_in.rd      = REG_AW_MAX'(dec.rd);
    entry_in.is_load = dec.is_load;
  end

  hazard_shadow_pipe #(
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .entry_in (entry_in),
    .entries  (flat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= ST_RUN;
      flush_left <= '0;
    end else begin
      case (st)
        ST_RUN, ST_STALL: begin
          if (dec.jump) begin
            if (FLUSH_CYCLES > 0) begin
              st         <= ST_FLUSH;
              flush_left <= FLUSH_RELOAD;
            end else begin
              st <= ST_RUN;
            end
          end else if (stall) begin
            st <= ST_STALL;
          end else begin
            st <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (dec.jump) begin
            flush_left <= FLUSH_RELOAD;
          end else if (flush_left == '0) begin
            st <= ST_RUN;
          end else begin
            flush_left <= flush_left - 3'd1;
          end
        end
        default: st <= ST_RUN;
      endcase
    end
  end

  assign state = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench over four configurations: default, WB bypass, forwarding, long flush with narrow counter.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic iv = 1'b0, we = 1'b0, ld = 1'b0, jmp = 1'b0, clr = 1'b0;
  logic [1:0] mask = '0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;

  logic        stall_v [4];
  logic        bubble_v[4];
  logic        flush_v [4];
  logic [1:0]  st_v    [4];
  logic [15:0] cnt0, cnt1, cnt2;
  logic [3:0]  cnt3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(5)) ifs[4] ();

  for (genvar g = 0; g < 4; g++) begin : g_bind
    assign ifs[g].issue_valid = iv;
    assign ifs[g].rd_mask     = mask;
    assign ifs[g].rs1         = rs1;
    assign ifs[g].rs2         = rs2;
    assign ifs[g].we          = we;
    assign ifs[g].rd          = rd;
    assign ifs[g].is_load     = ld;
    assign ifs[g].jump        = jmp;
    assign stall_v[g]         = ifs[g].stall_fd;
    assign bubble_v[g]        = ifs[g].bubble_e;
    assign flush_v[g]         = ifs[g].flush_fd;
  end

  hazard_scoreboard #(.NUM_REGS(32)) d0 (
    .clk(clk), .reset(reset), .dec(ifs[0]), .state(st_v[0]), .stall_cnt(cnt0), .stat_clr(clr));
  hazard_scoreboard #(.NUM_REGS(32), .WB_BYPASS(1)) d1 (
    .clk(clk), .reset(reset), .dec(ifs[1]), .state(st_v[1]), .stall_cnt(cnt1), .stat_clr(clr));
  hazard_scoreboard #(.NUM_REGS(32), .FWD_EN(1)) d2 (
    .clk(clk), .reset(reset), .dec(ifs[2]), .state(st_v[2]), .stall_cnt(cnt2), .stat_clr(clr));
  hazard_scoreboard #(.NUM_REGS(32), .FLUSH_CYCLES(2), .CNT_W(4)) d3 (
    .clk(clk), .reset(reset), .dec(ifs[3]), .state(st_v[3]), .stall_cnt(cnt3), .stat_clr(clr));

  typedef struct {
    logic       iv;
    logic [1:0] mask;
    logic [4:0] rs1, rs2;
    logic       we;
    logic [4:0] rd;
    logic       ld, jmp, clr;
    logic       e_stall, e_flush;
    logic [1:0] e_state;
    int         e_cnt;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic v, logic [1:0] m, logic [4:0] a, logic [4:0] b, logic w,
                              logic [4:0] d, logic l, logic j, logic c,
                              logic es, logic ef, logic [1:0] est, int ec);
    vec_t r;
    r.iv = v; r.mask = m; r.rs1 = a; r.rs2 = b; r.we = w; r.rd = d; r.ld = l; r.jmp = j; r.clr = c;
    r.e_stall = es; r.e_flush = ef; r.e_state = est; r.e_cnt = ec;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [4:0] a, input logic [4:0] b,
                       input logic w, input logic [4:0] d, input logic l, input logic j);
    iv = v; mask = m; rs1 = a; rs2 = b; we = w; rd = d; ld = l; jmp = j;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
    clr = 1'b0;
    reset = 1'b1;
    edge_step();
    reset = 1'b0;
  endtask

  int s[4];
  int f3;
  logic [1:0] es[7];
  logic       ef[7];
  logic       jp[7];

  initial begin
    tbl[0]  = mk(1, 2'b00, 0, 0, 1, 5, 0, 0, 0,  0, 0, ST_RUN,   0);
    tbl[1]  = mk(1, 2'b01, 5, 0, 0, 0, 0, 0, 0,  1, 0, ST_RUN,   0);
    tbl[2]  = mk(1, 2'b01, 5, 0, 0, 0, 0, 0, 0,  1, 0, ST_STALL, 1);
    tbl[3]  = mk(1, 2'b01, 5, 0, 0, 0, 0, 0, 0,  1, 0, ST_STALL, 2);
    tbl[4]  = mk(1, 2'b01, 5, 0, 0, 0, 0, 0, 0,  0, 0, ST_STALL, 3);
    tbl[5]  = mk(1, 2'b00, 0, 0, 1, 0, 0, 0, 0,  0, 0, ST_RUN,   3);
    tbl[6]  = mk(1, 2'b11, 0, 0, 1, 9, 0, 0, 0,  0, 0, ST_RUN,   3);
    tbl[7]  = mk(1, 2'b00, 9, 9, 0, 0, 0, 0, 0,  0, 0, ST_RUN,   3);
    tbl[8]  = mk(1, 2'b10, 0, 9, 0, 0, 0, 0, 0,  1, 0, ST_RUN,   3);
    tbl[9]  = mk(1, 2'b10, 0, 9, 0, 0, 0, 0, 0,  1, 0, ST_STALL, 4);
    tbl[10] = mk(1, 2'b01, 3, 0, 1, 3, 0, 0, 0,  0, 0, ST_STALL, 5);
    tbl[11] = mk(1, 2'b01, 3, 0, 0, 0, 0, 1, 0,  0, 1, ST_RUN,   5);
    tbl[12] = mk(1, 2'b01, 3, 0, 0, 0, 0, 0, 0,  0, 1, ST_FLUSH, 5);
    tbl[13] = mk(1, 2'b01, 3, 0, 0, 0, 0, 0, 0,  1, 0, ST_RUN,   5);
    tbl[14] = mk(1, 2'b01, 3, 0, 0, 0, 0, 0, 0,  0, 0, ST_STALL, 6);
    tbl[15] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1,  0, 0, ST_RUN,   6);
    tbl[16] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 0, ST_RUN,   0);
    tbl[17] = mk(1, 2'b00, 0, 0, 1, 4, 0, 0, 0,  0, 0, ST_RUN,   0);
    tbl[18] = mk(0, 2'b01, 4, 0, 0, 0, 0, 0, 0,  0, 0, ST_RUN,   0);

    // Reset state while reset is held
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("reset_stall[%0d]", g), stall_v[g], 0);
      chk($sformatf("reset_flush[%0d]", g), flush_v[g], 0);
      chk($sformatf("reset_state[%0d]", g), st_v[g], ST_RUN);
    end
    chk("reset_cnt0", cnt0, 0);
    edge_step();
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].iv, tbl[i].mask, tbl[i].rs1, tbl[i].rs2, tbl[i].we, tbl[i].rd, tbl[i].ld, tbl[i].jmp);
      clr = tbl[i].clr;
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), stall_v[0], tbl[i].e_stall);
      chk($sformatf("v%0d_flush", i), flush_v[0], tbl[i].e_flush);
      chk($sformatf("v%0d_bubble", i), bubble_v[0], tbl[i].e_stall | tbl[i].e_flush);
      chk($sformatf("v%0d_state", i), st_v[0], tbl[i].e_state);
      chk($sformatf("v%0d_cnt", i), cnt0, tbl[i].e_cnt);
      edge_step();
    end
    clr = 1'b0;

    // RAW with a non-load producer: stall length per configuration
    do_reset();
    drive(1, 2'b00, 0, 0, 1, 5, 0, 0);
    edge_step();
    drive(1, 2'b01, 5, 0, 0, 0, 0, 0);
    for (int g = 0; g < 4; g++) s[g] = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) s[g] += int'(stall_v[g]);
      edge_step();
    end
    chk("raw_default", s[0], 3);
    chk("raw_wb_bypass", s[1], 2);
    chk("raw_fwd_alu", s[2], 0);
    chk("raw_default_cnt", cnt0, 3);
    chk("raw_bypass_cnt", cnt1, 2);

    // Load-use with forwarding, read on rs2
    do_reset();
    drive(1, 2'b00, 0, 0, 1, 7, 1, 0);
    edge_step();
    drive(1, 2'b10, 0, 7, 0, 0, 0, 0);
    for (int g = 0; g < 4; g++) s[g] = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) s[g] += int'(stall_v[g]);
      edge_step();
    end
    chk("load_use_fwd", s[2], 1);
    chk("load_use_default", s[0], 3);

    // Jump coinciding with a hazard, FLUSH_CYCLES=2
    do_reset();
    drive(1, 2'b00, 0, 0, 1, 5, 0, 0);
    edge_step();
    drive(1, 2'b01, 5, 0, 0, 0, 0, 1);
    es[0] = ST_RUN; es[1] = ST_FLUSH; es[2] = ST_FLUSH; es[3] = ST_RUN; es[4] = ST_RUN;
    ef[0] = 1; ef[1] = 1; ef[2] = 1; ef[3] = 0; ef[4] = 0;
    f3 = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("jh%0d_flush", k), flush_v[3], ef[k]);
      chk($sformatf("jh%0d_stall", k), stall_v[3], 0);
      chk($sformatf("jh%0d_state", k), st_v[3], es[k]);
      f3 += int'(flush_v[3]);
      edge_step();
      jmp = 1'b0;
    end
    chk("jh_flush_cycles", f3, 3);

    // Second jump in the last FLUSH cycle reloads the counter
    do_reset();
    jp[0] = 1; jp[1] = 0; jp[2] = 1; jp[3] = 0; jp[4] = 0; jp[5] = 0; jp[6] = 0;
    ef[0] = 1; ef[1] = 1; ef[2] = 1; ef[3] = 1; ef[4] = 1; ef[5] = 0; ef[6] = 0;
    es[0] = ST_RUN; es[1] = ST_FLUSH; es[2] = ST_FLUSH; es[3] = ST_FLUSH;
    es[4] = ST_FLUSH; es[5] = ST_RUN; es[6] = ST_RUN;
    for (int k = 0; k < 7; k++) begin
      jmp = jp[k];
      @(negedge clk);
      chk($sformatf("bb%0d_flush", k), flush_v[3], ef[k]);
      chk($sformatf("bb%0d_state", k), st_v[3], es[k]);
      edge_step();
    end
    jmp = 1'b0;

    // Self-dependent instruction: three stalls per four cycles, narrow counter saturates
    do_reset();
    drive(1, 2'b01, 5, 0, 1, 5, 0, 0);
    for (int k = 0; k < 30; k++) edge_step();
    chk("sat_cnt_w4", cnt3, 15);
    chk("sat_cnt_w16", cnt0, 22);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
    clr = 1'b1;
    edge_step();
    clr = 1'b0;
    chk("clr_cnt_w4", cnt3, 0);
    chk("clr_cnt_w16", cnt0, 0);

    // Asynchronous reset in the middle of a stall
    drive(1, 2'b00, 0, 0, 1, 5, 0, 0);
    edge_step();
    drive(1, 2'b01, 5, 0, 0, 0, 0, 0);
    edge_step();
    chk("pre_reset_state", st_v[3], ST_STALL);
    chk("pre_reset_cnt", cnt3, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_stall", stall_v[3], 0);
    chk("rst_bubble", bubble_v[3], 0);
    chk("rst_flush", flush_v[3], 0);
    chk("rst_state", st_v[3], ST_RUN);
    chk("rst_cnt", cnt3, 0);
    edge_step();
    chk("rst_held_stall", stall_v[0], 0);
    reset = 1'b0;

    // Asynchronous reset in the middle of a flush
    drive(0, 2'b00, 0, 0, 0, 0, 0, 1);
    edge_step();
    jmp = 1'b0;
    chk("pre_rstf_state", st_v[3], ST_FLUSH);
    #2;
    reset = 1'b1;
    #1;
    chk("rstf_flush", flush_v[3], 0);
    chk("rstf_state", st_v[3], ST_RUN);
    edge_step();
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
